// File: rtl/onewire_xfer.sv
// onewire_xfer: 1-Wire bit-slot engine running 1..MAX_BITS write or read slots LSB first, reading the bus back each slot.
// Define ONEWIRE_STRONG_PULLUP_EN to build the strong-pullup phase (spu_req / strong_pullup ports, SPU state).
module onewire_xfer #(
    parameter int MAX_BITS    = 8,
    parameter int CLKS_PER_US = 27,
    parameter int T_SLOT_US   = 70,
    parameter int T_W1_US     = 6,
    parameter int T_W0_US     = 60,
    parameter int T_RD_US     = 6,
    parameter int T_SAMPLE_US = 15,
    parameter int T_SPU_US    = 750
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          read_mode,
    input  logic [MAX_BITS-1:0]           tx_data,
    input  logic [$clog2(MAX_BITS+1)-1:0] bit_count,
    input  logic                          line_in,
    output logic                          drive_low,
    output logic                          busy,
    output logic                          done,
    output logic [MAX_BITS-1:0]           rx_data
`ifdef ONEWIRE_STRONG_PULLUP_EN
    ,
    input  logic                          spu_req,
    output logic                          strong_pullup
`endif
);

    localparam int BC_W    = $clog2(MAX_BITS + 1);
    localparam int SLOT    = T_SLOT_US * CLKS_PER_US;
    localparam int W1      = T_W1_US * CLKS_PER_US;
    localparam int W0      = T_W0_US * CLKS_PER_US;
    localparam int RD      = T_RD_US * CLKS_PER_US;
    localparam int SMP     = T_SAMPLE_US * CLKS_PER_US;
    localparam int SPU     = T_SPU_US * CLKS_PER_US;
    localparam int CNT_MAX = (SLOT > SPU) ? SLOT : SPU;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_SLOT_LAST = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] C_W1        = CNT_W'(W1);
    localparam logic [CNT_W-1:0] C_W0        = CNT_W'(W0);
    localparam logic [CNT_W-1:0] C_RD        = CNT_W'(RD);
    localparam logic [CNT_W-1:0] C_SMP       = CNT_W'(SMP);
`ifdef ONEWIRE_STRONG_PULLUP_EN
    localparam logic [CNT_W-1:0] C_SPU_LAST  = CNT_W'(SPU - 1);
`endif
    localparam logic [BC_W-1:0]  C_MAX_BITS  = BC_W'(MAX_BITS);

    generate
        if (!(W1 >= 1 && RD >= 1 && W1 < SMP && RD < SMP && SMP < W0 && W0 < SLOT)) begin : g_param_check
            $error("onewire_xfer: slot timing parameters are out of order");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SLOT = 2'd1
`ifdef ONEWIRE_STRONG_PULLUP_EN
        ,
        S_SPU  = 2'd2
`endif
    } state_t;

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next, w_cnt_inc, w_low_cur;
    logic [BC_W-1:0]     r_idx, w_idx_next, r_nbits, w_nbits_next, w_count_clamped;
    logic [MAX_BITS-1:0] r_tx, w_tx_next, r_rx, w_rx_next, w_bit_mask;
    logic                r_mode, w_mode_next;
    logic                r_drive_low, w_drive_next;
    logic                r_busy, w_busy_next;
    logic                r_done, w_done_next;
    logic                w_tx_bit;
    logic [1:0]          r_sync;
`ifdef ONEWIRE_STRONG_PULLUP_EN
    logic                r_spu, w_spu_next;
    logic                r_strong_pullup, w_sp_next;
`endif

    assign w_cnt_inc       = r_cnt + CNT_W'(1);
    assign w_bit_mask      = MAX_BITS'(1) << r_idx;
    assign w_tx_bit        = |(r_tx & w_bit_mask);
    assign w_low_cur       = r_mode ? C_RD : (w_tx_bit ? C_W1 : C_W0);
    assign w_count_clamped = (bit_count > C_MAX_BITS) ? C_MAX_BITS : bit_count;

    // Next-state, slot timing and sampling decisions
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_cnt_inc;
        w_idx_next   = r_idx;
        w_nbits_next = r_nbits;
        w_tx_next    = r_tx;
        w_mode_next  = r_mode;
        w_rx_next    = r_rx;
        w_drive_next = 1'b0;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
`ifdef ONEWIRE_STRONG_PULLUP_EN
        w_spu_next   = r_spu;
        w_sp_next    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_next  = {CNT_W{1'b0}};
                w_busy_next = 1'b0;
                if (start) begin
                    w_tx_next    = tx_data;
                    w_mode_next  = read_mode;
                    w_nbits_next = w_count_clamped;
                    w_rx_next    = {MAX_BITS{1'b0}};
                    w_idx_next   = {BC_W{1'b0}};
`ifdef ONEWIRE_STRONG_PULLUP_EN
                    w_spu_next   = spu_req;
`endif
                    if (w_count_clamped == {BC_W{1'b0}}) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = S_SLOT;
                        w_busy_next  = 1'b1;
                        w_drive_next = 1'b1;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SLOT: begin
                w_drive_next = (w_cnt_inc < w_low_cur);
                if (r_cnt == C_SMP) begin
                    w_rx_next = r_sync[1] ? (r_rx | w_bit_mask) : (r_rx & ~w_bit_mask);
                end else begin
                    w_rx_next = r_rx;
                end
                if (r_cnt == C_SLOT_LAST) begin
                    w_cnt_next = {CNT_W{1'b0}};
                    if (r_idx == (r_nbits - BC_W'(1))) begin
                        w_drive_next = 1'b0;
`ifdef ONEWIRE_STRONG_PULLUP_EN
                        if (r_spu) begin
                            w_state_next = S_SPU;
                            w_sp_next    = 1'b1;
                        end else begin
                            w_state_next = S_IDLE;
                            w_busy_next  = 1'b0;
                            w_done_next  = 1'b1;
                        end
`else
                        w_state_next = S_IDLE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
`endif
                    end else begin
                        // Next slot starts immediately; its low phase begins on this edge.
                        w_idx_next   = r_idx + BC_W'(1);
                        w_drive_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
`ifdef ONEWIRE_STRONG_PULLUP_EN
            S_SPU: begin
                if (r_cnt == C_SPU_LAST) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = {CNT_W{1'b0}};
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end else begin
                    w_sp_next    = 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt           <= {CNT_W{1'b0}};
            r_idx           <= {BC_W{1'b0}};
            r_nbits         <= {BC_W{1'b0}};
            r_tx            <= {MAX_BITS{1'b0}};
            r_rx            <= {MAX_BITS{1'b0}};
            r_mode          <= 1'b0;
            r_drive_low     <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
`ifdef ONEWIRE_STRONG_PULLUP_EN
            r_spu           <= 1'b0;
            r_strong_pullup <= 1'b0;
`endif
        end else begin
            r_cnt           <= w_cnt_next;
            r_idx           <= w_idx_next;
            r_nbits         <= w_nbits_next;
            r_tx            <= w_tx_next;
            r_rx            <= w_rx_next;
            r_mode          <= w_mode_next;
            r_drive_low     <= w_drive_next;
            r_busy          <= w_busy_next;
            r_done          <= w_done_next;
`ifdef ONEWIRE_STRONG_PULLUP_EN
            r_spu           <= w_spu_next;
            r_strong_pullup <= w_sp_next;
`endif
        end
    end

    // Two-flop synchronizer for the asynchronous bus level (idle bus reads high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], line_in};
        end
    end

    assign drive_low = r_drive_low;
    assign busy      = r_busy;
    assign done      = r_done;
    assign rx_data   = r_rx;
`ifdef ONEWIRE_STRONG_PULLUP_EN
    assign strong_pullup = r_strong_pullup;
`endif

endmodule

// File: tb/tb_onewire_xfer.sv
// Self-checking bench for onewire_xfer: directed and random transfers against a slot-rule model and a bus/slave model.
module tb_onewire_xfer;

    localparam int SLOT = 70 * 27;
    localparam int SPU  = 750 * 27;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       read_mode = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [3:0] bit_count = 4'd0;
    logic       line_in;
    logic       drive_low, busy, done;
    logic [7:0] rx_data;
`ifdef ONEWIRE_STRONG_PULLUP_EN
    logic       spu_req = 1'b0;
    logic       strong_pullup;
    int         sp_run = 0;
    int         sp_start = 0;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int low_w[$];
    int low_s[$];
    int run = 0;
    int run_start = 0;

    logic       slave_en = 1'b0;
    logic [7:0] slave_data = 8'h00;
    int         sl_idx = 0;
    int         sl_hold = 0;
    logic       dl_prev = 1'b0;
    logic       slave_low;

    onewire_xfer dut (
        .clk(clk), .rst(rst), .start(start), .read_mode(read_mode),
        .tx_data(tx_data), .bit_count(bit_count), .line_in(line_in),
        .drive_low(drive_low), .busy(busy), .done(done), .rx_data(rx_data)
`ifdef ONEWIRE_STRONG_PULLUP_EN
        , .spu_req(spu_req), .strong_pullup(strong_pullup)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Open-drain bus: low if the master or the slave pulls it down.
    assign slave_low = (sl_hold > 0);
    assign line_in   = ~(drive_low | slave_low);

    // Slave: on each master falling edge, hold the line low for 30 us when returning a 0.
    always @(negedge clk) begin
        dl_prev <= drive_low;
        if (!busy) begin
            sl_idx  <= 0;
            sl_hold <= 0;
        end else if (drive_low && !dl_prev) begin
            sl_hold <= (slave_en && !slave_data[sl_idx]) ? 30 * 27 : 0;
            sl_idx  <= sl_idx + 1;
        end else if (sl_hold > 0) begin
            sl_hold <= sl_hold - 1;
        end
    end

    // Record every drive_low pulse: start cycle and width.
    always @(negedge clk) begin
        if (drive_low) begin
            if (run == 0) run_start <= cyc;
            run <= run + 1;
        end else if (run != 0) begin
            low_w.push_back(run);
            low_s.push_back(run_start);
            run <= 0;
        end
    end

`ifdef ONEWIRE_STRONG_PULLUP_EN
    always @(negedge clk) begin
        if (strong_pullup) begin
            if (sp_run == 0) sp_start <= cyc;
            sp_run <= sp_run + 1;
        end
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_low(input logic mode, input logic [7:0] tx, input int i);
        if (mode) return 6 * 27;
        else if (tx[i]) return 6 * 27;
        else return 60 * 27;
    endfunction

    task automatic kick(input logic mode, input logic [7:0] tx, input logic [3:0] bc,
                        output int acc, output int base);
        @(posedge clk); #1;
        read_mode = mode; tx_data = tx; bit_count = bc; start = 1'b1;
        base = low_w.size();
        @(posedge clk); #1;
        start = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        chk("done_seen", (dcyc >= 0), 1'b1);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
    endtask

    task automatic check_xfer(input string tag, input int acc, input int base, input int dcyc,
                              input logic mode, input logic [7:0] tx, input logic [7:0] sdata, input int n);
        int nl;
        logic [7:0] erx;
        nl = low_w.size() - base;
        chk({tag, "_slots"}, nl, n);
        for (int i = 0; i < n && i < nl; i++) begin
            chk($sformatf("%s_low%0d", tag, i), low_w[base + i], exp_low(mode, tx, i));
            chk($sformatf("%s_start%0d", tag, i), low_s[base + i] - acc, i * SLOT);
        end
        chk({tag, "_latency"}, dcyc - acc, n * SLOT);
        erx = 8'((mode ? int'(sdata) : int'(tx)) & ((1 << n) - 1));
        chk({tag, "_rx"}, rx_data, erx);
    endtask

    initial begin
        int acc, base, dcyc, target, n;
        logic       m;
        logic [7:0] t, s;
        logic [3:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_drive_low", drive_low, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rx", rx_data, 8'h00);
`ifdef ONEWIRE_STRONG_PULLUP_EN
        chk("rst_spu", strong_pullup, 1'b0);
`endif
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Write 0xA5, 8 bits, bus follows the master
        kick(1'b0, 8'hA5, 4'd8, acc, base);
        wait_done(8 * SLOT + 20, dcyc);
        check_xfer("wrA5", acc, base, dcyc, 1'b0, 8'hA5, 8'h00, 8);

        // Read 4 bits; slave returns 0 on the 1st and 3rd slots
        slave_en = 1'b1; slave_data = 8'h0A;
        kick(1'b1, 8'h00, 4'd4, acc, base);
        wait_done(4 * SLOT + 20, dcyc);
        check_xfer("rd4", acc, base, dcyc, 1'b1, 8'h00, 8'h0A, 4);
        slave_en = 1'b0;

        // Zero-length transfer: immediate done, no slots, rx cleared
        kick(1'b0, 8'hFF, 4'd0, acc, base);
        chk("bc0_busy", busy, 1'b0);
        wait_done(20, dcyc);
        check_xfer("bc0", acc, base, dcyc, 1'b0, 8'hFF, 8'h00, 0);

        // Count 15 clamps to 8; start pulsed at cycle 500 of slot 2 must be ignored
        kick(1'b0, 8'h3C, 4'd15, acc, base);
        target = acc + 2 * SLOT + 500;
        while (cyc < target - 1) begin @(posedge clk); #1; end
        start = 1'b1; tx_data = 8'hC3; bit_count = 4'd1; read_mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(8 * SLOT + 20, dcyc);
        check_xfer("clamp_ign", acc, base, dcyc, 1'b0, 8'h3C, 8'h00, 8);

        // Async reset while drive_low is high in slot 1
        kick(1'b0, 8'h03, 4'd2, acc, base);
        target = acc + SLOT + 100;
        while (cyc < target) begin @(posedge clk); #1; end
        chk("prerst_drive", drive_low, 1'b1);
        chk("prerst_rx", rx_data, 8'h01);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_drive", drive_low, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rx", rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        kick(1'b0, 8'h02, 4'd2, acc, base);
        wait_done(2 * SLOT + 20, dcyc);
        check_xfer("postrst", acc, base, dcyc, 1'b0, 8'h02, 8'h00, 2);

        // Random short transfers
        for (int r = 0; r < 2; r++) begin
            m = 1'($urandom_range(1, 0));
            t = 8'($urandom);
            s = 8'($urandom);
            b = 4'($urandom_range(2, 1));
            n = (b > 4'd8) ? 8 : int'(b);
            slave_en = m; slave_data = s;
            kick(m, t, b, acc, base);
            wait_done(n * SLOT + 20, dcyc);
            check_xfer($sformatf("rnd%0d", r), acc, base, dcyc, m, t, s, n);
        end
        slave_en = 1'b0;

`ifdef ONEWIRE_STRONG_PULLUP_EN
        // Strong pullup after writing 0x44; start during SPU ignored
        spu_req = 1'b1;
        kick(1'b0, 8'h44, 4'd8, acc, base);
        spu_req = 1'b0;
        target = acc + 8 * SLOT + 1000;
        while (cyc < target - 1) begin @(posedge clk); #1; end
        start = 1'b1; tx_data = 8'hFF; bit_count = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("spu_drive", drive_low, 1'b0);
        chk("spu_busy", busy, 1'b1);
        chk("spu_level", strong_pullup, 1'b1);
        wait_done(8 * SLOT + SPU + 20, dcyc);
        repeat (20) @(negedge clk);
        chk("spu_latency", dcyc - acc, 8 * SLOT + SPU);
        chk("spu_len", sp_run, SPU);
        chk("spu_start", sp_start - acc, 8 * SLOT);
        chk("spu_slots", low_w.size() - base, 8);
        chk("spu_rx", rx_data, 8'h44);
        chk("spu_idle_busy", busy, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
